// File: rtl/subservient_pkg.sv
// Shared types and constants for the subservient SRAM loader.
// Holds the loader FSM encoding and the full-word byte-select constant.
package subservient_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hf;

endpackage

// File: rtl/subservient_loader_if.sv
// Byte stream (valid/ready) plus 32-bit Wishbone write port of the loader.
// master: loader side (consumes bytes, drives the bus); slave: stream source + arbiter.
interface subservient_loader_if #(
    parameter int aw = 8
);
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic [aw-3:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          stb;
    logic          ack;

    modport master (
        input  data, valid, ack,
        output ready, adr, dat, sel, we, stb
    );

    modport slave (
        output data, valid, ack,
        input  ready, adr, dat, sel, we, stb
    );
endinterface

// File: rtl/subservient_loader.sv
// Fills the shared RF/data SRAM from a byte stream, one full-word Wishbone write
// per 4 bytes (little-endian), holding the CPU in reset until the load is done.
// Ports: i_clk, i_rst_n (async, active low), i_start/i_nwords (load request),
// bus (stream in + Wishbone out), o_cpu_rst (active high), o_done.
module subservient_loader
    import subservient_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [aw-2:0]        i_nwords,
    subservient_loader_if.master bus,
    output logic                 o_cpu_rst,
    output logic                 o_done
);

    localparam int CW = aw - 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   nwords;
    logic [1:0]      bidx;
    logic [31:0]     dat;
    logic            accept;

    assign accept  = bus.valid && (state == COLLECT);
    // Counter is one bit wider than the address so depth/4 words fit.
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_start)
                    state_nxt = (i_nwords == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                if (accept && bidx == 2'd3)
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (bus.ack)
                    state_nxt = (cnt_inc == nwords) ? DONE : COLLECT;
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            nwords <= '0;
            bidx   <= '0;
            dat    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_start) begin
                nwords <= i_nwords;
                cnt    <= '0;
                bidx   <= '0;
            end
            if (accept) begin
                dat[{bidx, 3'b000} +: 8] <= bus.data;
                bidx <= bidx + 2'd1;
            end
            if (state == WRITE && bus.ack)
                cnt <= cnt_inc;
        end
    end

    // All outputs are registers or pure state decodes.
    assign bus.ready = (state == COLLECT);
    assign bus.stb   = (state == WRITE);
    assign bus.we    = (state == WRITE);
    assign bus.sel   = (state == WRITE) ? WB_SEL_ALL : 4'h0;
    assign bus.adr   = cnt[aw-3:0];
    assign bus.dat   = dat;
    assign o_done    = (state == DONE);
    assign o_cpu_rst = (state != DONE);

endmodule
